mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-client front end for `mem_controller`. It accepts instruction-fetch requests from the fetch stage and load/store requests from the execute stage. It grants one at a time using round-robin and drives the level-held `start_request`/`request_done` handshake of `mem_controller`. A one-entry instruction buffer answers a repeated fetch of the same word without an SPI transaction.

## Interface
- `DATA_W`, 32: address and data width.
- `clk` in 1: system clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `if_req` in 1: fetch request, level; held until `if_done`.
- `if_addr` in 32: fetch address, stable while `if_req`.
- `if_done` out 1: one-cycle completion pulse.
- `if_rdata` out 32: fetched word, valid with `if_done` and held afterwards.
- `d_req` in 1: data request, level; held until `d_done`.
- `d_is_write` in 1: 1 = store, 0 = load.
- `d_num_bytes` in 3: byte count, 1, 2 or 4.
- `d_addr` in 32: data address.
- `d_wdata` in 32: store data.
- `d_done` out 1: one-cycle completion pulse.
- `d_rdata` out 32: load data, valid with `d_done` and held afterwards. It is not updated by stores.
- `mem_start_request` out 1: to `mem_controller.start_request`.
- `mem_is_write` out 1: to `mem_controller`.
- `mem_num_bytes` out 3: to `mem_controller`.
- `mem_target_address` out 32: to `mem_controller`.
- `mem_write_value` out 32: to `mem_controller`.
- `mem_is_data_fetch` out 1: 1 for the data port, 0 for fetch.
- `mem_fetched_data` in 32: from `mem_controller.fetched_data`.
- `mem_request_done` in 1: from `mem_controller.request_done`.

## Operation
- States:
  - IDLE: arbitrate.
  - ISSUE: `mem_start_request`=1, waiting for `mem_request_done`.
  - RELEASE: `mem_start_request`=0 for one cycle; the client's done pulse is asserted here.
  - HIT: serve the fetch from the buffer; done pulse asserted, no memory access.
- IDLE transitions:
  - Only `d_req`: grant data.
  - Only `if_req` with a buffer miss: grant fetch.
  - Only `if_req` with a buffer hit: go to HIT.
  - Both requests: grant the client not granted last (`last_grant` flag). A buffer hit counts as a fetch grant.
- On grant, the request fields are latched into `mem_*` registers:
  - Fetch: `mem_is_write`=0, `mem_num_bytes`=4, `mem_is_data_fetch`=0.
  - Data: values copied from the `d_*` inputs, `mem_is_data_fetch`=1.
- In ISSUE, `mem_request_done`=1 does two things:
  - Captures `mem_fetched_data` into the granted client's rdata register.
  - Moves to RELEASE.
- RELEASE and HIT always return to IDLE. `mem_start_request` is therefore low for at least one cycle between transactions, which guarantees a fresh rising edge at `mem_controller`.
- Instruction buffer (one entry: `buf_valid`, `buf_addr[31:0]`, `buf_data[31:0]`):
  - Filled on completion of every fetch grant.
  - Hit when `buf_valid` && `if_addr`==`buf_addr`.
  - Invalidated when a store completes with `d_addr[31:2]`==`buf_addr[31:2]`.
  - Loads never invalidate it.
- Requests that deassert before their done pulse are a protocol violation; behaviour is undefined.

## Timing
- Reset values:
  - State IDLE; `last_grant`=data, so a simultaneous first request goes to fetch.
  - All outputs 0: `mem_start_request`, `mem_is_write`, `mem_num_bytes`, `mem_target_address`, `mem_write_value`, `mem_is_data_fetch`, `if_done`, `d_done`, `if_rdata`, `d_rdata`.
  - `buf_valid`=0.
- Memory latency:
  - Request seen in IDLE at cycle 0 → `mem_start_request`=1 from cycle 1.
  - `mem_request_done` high at cycle N → done pulse and rdata at cycle N+1 → IDLE at N+2.
  - A held request can be re-granted at N+2, giving the next `mem_start_request` at N+3.
- Buffer hit latency: request at cycle 0 → `if_done` at cycle 1 → IDLE at cycle 2.
- All `mem_*` outputs are registered and constant throughout ISSUE.
- Simultaneous store to the buffered word and fetch of that word:
  - Arbitration is by `last_grant`.
  - If the store goes first, the fetch is evaluated after the invalidation and misses.
- Reset mid-operation:
  - Returns to IDLE immediately; all outputs drop to their reset values.
  - No done pulse is issued.
  - `mem_controller` shares `rst_n` and aborts its SPI transfer.

## Structure
- Shared package `mem_pkg` holds:
  - State enum (IDLE, ISSUE, RELEASE, HIT).
  - Grant encoding (`GRANT_IF`, `GRANT_D`).
  - `NUM_BYTES_WORD`=3'd4.
- Sub-module `ifetch_buffer`: single entry with fill, lookup (hit output), data output and word-address invalidate port.

## Test plan
- Fetch `if_addr`=0x100, memory returns 0x00A00093 after 40 cycles → `mem_num_bytes`=4, `mem_is_data_fetch`=0, `if_rdata`=0x00A00093, exactly one `if_done`.
- Second fetch of 0x100 → `if_done` one cycle after the request, `mem_start_request` stays 0.
- Store `d_addr`=0x102, `d_num_bytes`=2, `d_wdata`=0xBEEF, then fetch 0x100 → `mem_is_write`=1, `mem_write_value`=0xBEEF, `mem_num_bytes`=2 on the store; buffer invalidated and the fetch goes to memory.
- `if_req` and `d_req` raised in the same cycle and held for three transactions each → grants alternate fetch, data, fetch, …; `mem_start_request` low for ≥1 cycle between each.
- Load `d_addr`=0x2000, `d_num_bytes`=1, memory returns 0x0000007F → `d_rdata`=0x7F, `if_rdata` unchanged.
- `rst_n` pulled low mid-ISSUE → `mem_start_request` drops asynchronously, no done pulse, buffer miss on the next fetch of 0x100.

Source files
------------

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and constants for the memory arbiter
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RELEASE = 2'd2,
    HIT     = 2'd3
  } state_t;

  typedef enum logic {
    GRANT_IF = 1'b0,
    GRANT_D  = 1'b1
  } grant_t;

  localparam logic [2:0] NUM_BYTES_WORD = 3'd4;

endpackage

// File: rtl/ifetch_buffer.sv
// rtl/ifetch_buffer.sv - single-entry instruction word buffer
module ifetch_buffer
  import mem_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fill,
  input  logic [DATA_W-1:0] fill_addr,
  input  logic [DATA_W-1:0] fill_data,
  input  logic              inval,
  input  logic [DATA_W-3:0] inval_word,
  input  logic [DATA_W-1:0] lookup_addr,
  output logic              hit,
  output logic [DATA_W-1:0] data
);

  logic              valid;
  logic [DATA_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;

  // Fill takes priority; a store to any byte of the buffered word drops the entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid  <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else if (fill) begin
      valid  <= 1'b1;
      addr_q <= fill_addr;
      data_q <= fill_data;
    end else if (inval && (inval_word == addr_q[DATA_W-1:2])) begin
      valid  <= 1'b0;
    end
  end

  assign hit  = valid && (lookup_addr == addr_q);
  assign data = data_q;

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin fetch/data front end for mem_controller
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [DATA_W-1:0] if_addr,
  output logic              if_done,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_is_write,
  input  logic [2:0]        d_num_bytes,
  input  logic [DATA_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_start_request,
  output logic              mem_is_write,
  output logic [2:0]        mem_num_bytes,
  output logic [DATA_W-1:0] mem_target_address,
  output logic [DATA_W-1:0] mem_write_value,
  output logic              mem_is_data_fetch,
  input  logic [DATA_W-1:0] mem_fetched_data,
  input  logic              mem_request_done
);

  state_t            state;
  grant_t            last_grant;
  logic              pick_if;
  logic              buf_hit;
  logic [DATA_W-1:0] buf_data;
  logic              buf_fill;
  logic              buf_inval;

  // last_grant doubles as the owner of the transaction in flight.
  assign buf_fill  = (state == ISSUE) && mem_request_done && (last_grant == GRANT_IF);
  assign buf_inval = (state == ISSUE) && mem_request_done && (last_grant == GRANT_D) && mem_is_write;

  // Fetch wins when it is alone or when data was served last.
  assign pick_if = if_req && (!d_req || (last_grant == GRANT_D));

  ifetch_buffer #(.DATA_W(DATA_W)) u_ifetch_buffer (
    .clk         (clk),
    .rst_n       (rst_n),
    .fill        (buf_fill),
    .fill_addr   (mem_target_address),
    .fill_data   (mem_fetched_data),
    .inval       (buf_inval),
    .inval_word  (mem_target_address[DATA_W-1:2]),
    .lookup_addr (if_addr),
    .hit         (buf_hit),
    .data        (buf_data)
  );

  // Arbitration and handshake FSM; all client and memory outputs are registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= IDLE;
      last_grant         <= GRANT_D;
      if_done            <= 1'b0;
      if_rdata           <= '0;
      d_done             <= 1'b0;
      d_rdata            <= '0;
      mem_start_request  <= 1'b0;
      mem_is_write       <= 1'b0;
      mem_num_bytes      <= '0;
      mem_target_address <= '0;
      mem_write_value    <= '0;
      mem_is_data_fetch  <= 1'b0;
    end else begin
      if_done <= 1'b0;
      d_done  <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_if) begin
            last_grant <= GRANT_IF;
            if (buf_hit) begin
              state    <= HIT;
              if_done  <= 1'b1;
              if_rdata <= buf_data;
            end else begin
              state              <= ISSUE;
              mem_start_request  <= 1'b1;
              mem_is_write       <= 1'b0;
              mem_num_bytes      <= NUM_BYTES_WORD;
              mem_target_address <= if_addr;
              mem_write_value    <= '0;
              mem_is_data_fetch  <= 1'b0;
            end
          end else if (d_req) begin
            last_grant         <= GRANT_D;
            state              <= ISSUE;
            mem_start_request  <= 1'b1;
            mem_is_write       <= d_is_write;
            mem_num_bytes      <= d_num_bytes;
            mem_target_address <= d_addr;
            mem_write_value    <= d_wdata;
            mem_is_data_fetch  <= 1'b1;
          end
        end
        ISSUE: begin
          if (mem_request_done) begin
            state             <= RELEASE;
            mem_start_request <= 1'b0;
            if (last_grant == GRANT_IF) begin
              if_done  <= 1'b1;
              if_rdata <= mem_fetched_data;
            end else begin
              d_done <= 1'b1;
              if (!mem_is_write) d_rdata <= mem_fetched_data;
            end
          end
        end
        RELEASE: state <= IDLE;
        HIT:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_done;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_is_write;
  logic [2:0]  d_num_bytes;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_done;
  logic [31:0] d_rdata;
  logic        mem_start_request;
  logic        mem_is_write;
  logic [2:0]  mem_num_bytes;
  logic [31:0] mem_target_address;
  logic [31:0] mem_write_value;
  logic        mem_is_data_fetch;
  logic [31:0] mem_fetched_data;
  logic        mem_request_done;

  int checks = 0;
  int errors = 0;

  int          lat = 3;
  logic [31:0] resp_data = 32'h0;
  bit          resp_from_addr = 1'b0;

  int if_done_cnt = 0;
  int d_done_cnt  = 0;
  int start_rises = 0;
  int unstable    = 0;
  int grant_log[$];

  always #5 clk = ~clk;

  mem_arbiter #(.DATA_W(32)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .if_req             (if_req),
    .if_addr            (if_addr),
    .if_done            (if_done),
    .if_rdata           (if_rdata),
    .d_req              (d_req),
    .d_is_write         (d_is_write),
    .d_num_bytes        (d_num_bytes),
    .d_addr             (d_addr),
    .d_wdata            (d_wdata),
    .d_done             (d_done),
    .d_rdata            (d_rdata),
    .mem_start_request  (mem_start_request),
    .mem_is_write       (mem_is_write),
    .mem_num_bytes      (mem_num_bytes),
    .mem_target_address (mem_target_address),
    .mem_write_value    (mem_write_value),
    .mem_is_data_fetch  (mem_is_data_fetch),
    .mem_fetched_data   (mem_fetched_data),
    .mem_request_done   (mem_request_done)
  );

  // Memory controller model: level-held done after `lat` cycles of start_request.
  initial begin
    int cnt;
    cnt = 0;
    mem_request_done = 1'b0;
    mem_fetched_data = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_start_request && !mem_request_done) begin
        cnt++;
        if (cnt >= lat) begin
          mem_request_done = 1'b1;
          mem_fetched_data = resp_from_addr ? mem_target_address + 32'h1000_0000 : resp_data;
        end
      end else if (!mem_start_request) begin
        mem_request_done = 1'b0;
        cnt = 0;
      end
    end
  end

  // Observer: done pulses, start_request rising edges, field stability during ISSUE.
  initial begin
    logic        prev_start;
    logic [68:0] prev_fields;
    logic [68:0] fields;
    prev_start  = 1'b0;
    prev_fields = '0;
    forever begin
      @(negedge clk);
      fields = {mem_is_write, mem_num_bytes, mem_target_address, mem_write_value, mem_is_data_fetch};
      if (if_done) if_done_cnt++;
      if (d_done)  d_done_cnt++;
      if (mem_start_request && !prev_start) begin
        start_rises++;
        grant_log.push_back(int'(mem_is_data_fetch));
      end
      if (mem_start_request && prev_start && (fields != prev_fields)) unstable++;
      prev_start  = mem_start_request;
      prev_fields = fields;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Waits (bounded) for if_done (which=0) or d_done (which=1) at a negedge.
  task automatic wait_done(input int which, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if ((which == 0 && if_done) || (which == 1 && d_done)) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    bit ok;
    int c0;
    int r0;
    int base;
    int if_served;
    int d_served;

    rst_n = 1'b0;
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_is_write = 1'b0; d_num_bytes = '0; d_addr = '0; d_wdata = '0;
    step(3);
    chk("rst_start", 32'(mem_start_request), 32'd0);
    chk("rst_nb", 32'(mem_num_bytes), 32'd0);
    chk("rst_addr", mem_target_address, 32'd0);
    chk("rst_wval", mem_write_value, 32'd0);
    chk("rst_dfetch", 32'(mem_is_data_fetch), 32'd0);
    chk("rst_done", 32'({if_done, d_done, mem_is_write}), 32'd0);
    chk("rst_rdata", if_rdata | d_rdata, 32'd0);
    rst_n = 1'b1;
    step(2);

    // Fetch miss with 40-cycle memory latency
    lat = 40; resp_data = 32'h00A0_0093;
    c0 = if_done_cnt;
    if_req = 1'b1; if_addr = 32'h100;
    step(1);
    chk("f1_start", 32'(mem_start_request), 32'd1);
    chk("f1_nb", 32'(mem_num_bytes), 32'd4);
    chk("f1_dfetch", 32'(mem_is_data_fetch), 32'd0);
    chk("f1_write", 32'(mem_is_write), 32'd0);
    chk("f1_addr", mem_target_address, 32'h100);
    wait_done(0, ok);
    chk("f1_timeout", 32'(ok), 32'd1);
    chk("f1_rdata", if_rdata, 32'h00A0_0093);
    if_req = 1'b0;
    step(1);
    chk("f1_pulse_len", 32'(if_done), 32'd0);
    chk("f1_start_low", 32'(mem_start_request), 32'd0);
    step(2);
    chk("f1_one_done", 32'(if_done_cnt - c0), 32'd1);

    // Repeated fetch of the same word is served from the buffer
    r0 = start_rises;
    if_req = 1'b1; if_addr = 32'h100;
    step(1);
    chk("hit_done", 32'(if_done), 32'd1);
    chk("hit_rdata", if_rdata, 32'h00A0_0093);
    chk("hit_start", 32'(mem_start_request), 32'd0);
    if_req = 1'b0;
    step(1);
    chk("hit_pulse_len", 32'(if_done), 32'd0);
    step(2);
    chk("hit_no_mem", 32'(start_rises - r0), 32'd0);

    // Halfword store into the buffered word, then a fetch that must miss
    lat = 5; resp_data = 32'hDEAD_BEEF;
    d_req = 1'b1; d_is_write = 1'b1; d_num_bytes = 3'd2; d_addr = 32'h102; d_wdata = 32'h0000_BEEF;
    step(1);
    chk("st_write", 32'(mem_is_write), 32'd1);
    chk("st_wval", mem_write_value, 32'h0000_BEEF);
    chk("st_nb", 32'(mem_num_bytes), 32'd2);
    chk("st_dfetch", 32'(mem_is_data_fetch), 32'd1);
    chk("st_addr", mem_target_address, 32'h102);
    wait_done(1, ok);
    chk("st_timeout", 32'(ok), 32'd1);
    chk("st_no_rdata", d_rdata, 32'd0);
    d_req = 1'b0; d_is_write = 1'b0;
    step(2);
    resp_data = 32'h1111_1111;
    if_req = 1'b1; if_addr = 32'h100;
    step(1);
    chk("inval_miss", 32'(mem_start_request), 32'd1);
    wait_done(0, ok);
    chk("inval_timeout", 32'(ok), 32'd1);
    chk("inval_rdata", if_rdata, 32'h1111_1111);
    if_req = 1'b0;
    step(2);

    // Byte load leaves the fetch data untouched
    resp_data = 32'h0000_007F;
    d_req = 1'b1; d_is_write = 1'b0; d_num_bytes = 3'd1; d_addr = 32'h2000;
    step(1);
    chk("ld_nb", 32'(mem_num_bytes), 32'd1);
    chk("ld_write", 32'(mem_is_write), 32'd0);
    chk("ld_dfetch", 32'(mem_is_data_fetch), 32'd1);
    wait_done(1, ok);
    chk("ld_timeout", 32'(ok), 32'd1);
    chk("ld_rdata", d_rdata, 32'h0000_007F);
    chk("ld_if_rdata", if_rdata, 32'h1111_1111);
    d_req = 1'b0;
    step(2);

    // Both clients held for three transactions each: grants must alternate
    resp_from_addr = 1'b1; lat = 4;
    base = grant_log.size();
    r0 = start_rises;
    if_served = 0; d_served = 0;
    if_addr = 32'h200; d_addr = 32'h3000; d_num_bytes = 3'd4; d_is_write = 1'b0;
    if_req = 1'b1; d_req = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (if_done) begin
        chk("alt_if_rdata", if_rdata, if_addr + 32'h1000_0000);
        if_served++;
        if (if_served == 3) if_req = 1'b0; else if_addr = if_addr + 32'd4;
      end
      if (d_done) begin
        chk("alt_d_rdata", d_rdata, d_addr + 32'h1000_0000);
        d_served++;
        if (d_served == 3) d_req = 1'b0; else d_addr = d_addr + 32'd4;
      end
      if (if_served == 3 && d_served == 3) break;
    end
    chk("alt_if_served", 32'(if_served), 32'd3);
    chk("alt_d_served", 32'(d_served), 32'd3);
    step(2);
    chk("alt_rises", 32'(start_rises - r0), 32'd6);
    if (grant_log.size() - base == 6) begin
      for (int k = 0; k < 6; k++) chk("alt_order", 32'(grant_log[base + k]), 32'(k % 2));
    end else begin
      chk("alt_log_len", 32'(grant_log.size() - base), 32'd6);
    end
    resp_from_addr = 1'b0;

    // Re-buffer 0x100, then reset in the middle of a long load
    lat = 3; resp_data = 32'hCAFE_0001;
    if_req = 1'b1; if_addr = 32'h100;
    wait_done(0, ok);
    chk("rb_timeout", 32'(ok), 32'd1);
    if_req = 1'b0;
    step(2);
    lat = 1000;
    c0 = d_done_cnt;
    d_req = 1'b1; d_addr = 32'h40; d_num_bytes = 3'd4;
    step(1);
    chk("rs_start", 32'(mem_start_request), 32'd1);
    step(5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rs_async_start", 32'(mem_start_request), 32'd0);
    chk("rs_addr", mem_target_address, 32'd0);
    chk("rs_dfetch", 32'(mem_is_data_fetch), 32'd0);
    chk("rs_rdata", if_rdata, 32'd0);
    d_req = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(2);
    chk("rs_no_done", 32'(d_done_cnt - c0), 32'd0);
    lat = 3; resp_data = 32'h5555_AAAA;
    if_req = 1'b1; if_addr = 32'h100;
    step(1);
    chk("rs_miss", 32'(mem_start_request), 32'd1);
    wait_done(0, ok);
    chk("rs_f_timeout", 32'(ok), 32'd1);
    chk("rs_f_rdata", if_rdata, 32'h5555_AAAA);
    if_req = 1'b0;
    step(2);

    chk("issue_stable", 32'(unstable), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
